// File: rtl/idct_block_scheduler.sv
// idct_block_scheduler: frame-level sequencer for the milestone 2 IDCT.
// Overlaps fetch / compute T / compute S / write S across every block.
module idct_block_scheduler #(
   parameter int BLK_ROWS    = 30,
   parameter int Y_BLK_COLS  = 40,
   parameter int UV_BLK_COLS = 20,
   parameter int PRE_Y_BASE  = 76800,
   parameter int PRE_U_BASE  = 153600,
   parameter int PRE_V_BASE  = 192000,
   parameter int OUT_Y_BASE  = 0,
   parameter int OUT_U_BASE  = 38400,
   parameter int OUT_V_BASE  = 57600
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        fetch_start,
   input  logic        fetch_done,
   output logic [17:0] fetch_base,
   output logic        fetch_uv,
   output logic        ct_start,
   input  logic        ct_done,
   output logic        cs_start,
   input  logic        cs_done,
   output logic        ws_start,
   input  logic        ws_done,
   output logic [17:0] ws_base,
   output logic        ws_uv
);

   localparam int NBLK = BLK_ROWS * (Y_BLK_COLS + 2 * UV_BLK_COLS);
   localparam logic [11:0] LAST_BLK    = 12'(NBLK - 1);
   localparam logic [4:0]  ROW_LAST    = 5'(BLK_ROWS - 1);
   localparam logic [5:0]  Y_COL_LAST  = 6'(Y_BLK_COLS - 1);
   localparam logic [5:0]  UV_COL_LAST = 6'(UV_BLK_COLS - 1);
   localparam logic [17:0] F_ROW_Y     = 18'(Y_BLK_COLS * 64);
   localparam logic [17:0] F_ROW_UV    = 18'(UV_BLK_COLS * 64);
   localparam logic [17:0] W_ROW_Y     = 18'(Y_BLK_COLS * 32);
   localparam logic [17:0] W_ROW_UV    = 18'(UV_BLK_COLS * 32);

   typedef struct packed {
      logic [1:0]  pl;
      logic [4:0]  brow;
      logic [5:0]  bcol;
      logic [17:0] row;
      logic [17:0] col;
   } pos_t;

   localparam pos_t F_INIT = '{pl: 2'd0, brow: 5'd0, bcol: 6'd0,
                               row: 18'(PRE_Y_BASE), col: 18'd0};
   localparam pos_t W_INIT = '{pl: 2'd0, brow: 5'd0, bcol: 6'd0,
                               row: 18'(OUT_Y_BASE), col: 18'd0};

   typedef enum logic [2:0] {
      S_IDLE, S_LEAD_IN, S_MEGA_A, S_MEGA_B, S_LEAD_OUT, S_DONE
   } state_t;

   // Row-start register steps by a block row; column offset by a block width.
   function automatic pos_t pos_next(input pos_t p,
                                     input logic [17:0] step_y,
                                     input logic [17:0] step_uv,
                                     input logic [17:0] col_step,
                                     input logic [17:0] base_u,
                                     input logic [17:0] base_v);
      pos_t n;
      logic [5:0] last;
      n = p;
      last = (p.pl == 2'd0) ? Y_COL_LAST : UV_COL_LAST;
      if (p.bcol == last) begin
         n.bcol = '0;
         n.col  = '0;
         if (p.brow == ROW_LAST) begin
            n.brow = '0;
            n.pl   = p.pl + 2'd1;
            n.row  = (p.pl == 2'd0) ? base_u : base_v;
         end else begin
            n.brow = p.brow + 5'd1;
            n.row  = p.row + ((p.pl == 2'd0) ? step_y : step_uv);
         end
      end else begin
         n.bcol = p.bcol + 6'd1;
         n.col  = p.col + col_step;
      end
      return n;
   endfunction

   state_t      r_state;
   logic [11:0] r_blk;
   pos_t        r_fpos, r_wpos;
   pos_t        w_fpos_n, w_wpos_n;
   logic        r_f_pend, r_f_got, r_ct_pend, r_ct_got;
   logic        r_cs_pend, r_cs_got, r_ws_pend, r_ws_got;
   logic        w_f_ok, w_ct_ok, w_cs_ok, w_ws_ok;

   assign w_fpos_n = pos_next(r_fpos, F_ROW_Y, F_ROW_UV, 18'd8,
                              18'(PRE_U_BASE), 18'(PRE_V_BASE));
   assign w_wpos_n = pos_next(r_wpos, W_ROW_Y, W_ROW_UV, 18'd4,
                              18'(OUT_U_BASE), 18'(OUT_V_BASE));

   // A done seen in the deciding cycle itself already counts.
   assign w_f_ok  = r_f_got  | (fetch_done & r_f_pend);
   assign w_ct_ok = r_ct_got | (ct_done & r_ct_pend);
   assign w_cs_ok = r_cs_got | (cs_done & r_cs_pend);
   assign w_ws_ok = r_ws_got | (ws_done & r_ws_pend);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state     <= S_IDLE;
         r_blk       <= '0;
         r_fpos      <= F_INIT;
         r_wpos      <= W_INIT;
         {r_f_pend, r_f_got, r_ct_pend, r_ct_got} <= '0;
         {r_cs_pend, r_cs_got, r_ws_pend, r_ws_got} <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         fetch_start <= 1'b0;
         ct_start    <= 1'b0;
         cs_start    <= 1'b0;
         ws_start    <= 1'b0;
         fetch_base  <= '0;
         fetch_uv    <= 1'b0;
         ws_base     <= '0;
         ws_uv       <= 1'b0;
      end else begin
         fetch_start <= 1'b0;
         ct_start    <= 1'b0;
         cs_start    <= 1'b0;
         ws_start    <= 1'b0;
         done        <= 1'b0;
         if (fetch_done && r_f_pend) begin
            r_f_got  <= 1'b1;
            r_f_pend <= 1'b0;
         end
         if (ct_done && r_ct_pend) begin
            r_ct_got  <= 1'b1;
            r_ct_pend <= 1'b0;
         end
         if (cs_done && r_cs_pend) begin
            r_cs_got  <= 1'b1;
            r_cs_pend <= 1'b0;
         end
         if (ws_done && r_ws_pend) begin
            r_ws_got  <= 1'b1;
            r_ws_pend <= 1'b0;
         end
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_LEAD_IN;
                  busy        <= 1'b1;
                  r_blk       <= '0;
                  fetch_start <= 1'b1;
                  fetch_base  <= r_fpos.row + r_fpos.col;
                  fetch_uv    <= (r_fpos.pl != 2'd0);
                  r_fpos      <= w_fpos_n;
                  r_f_pend    <= 1'b1;
                  r_f_got     <= 1'b0;
               end
            end
            S_LEAD_IN: begin
               if (w_f_ok) begin
                  r_state   <= S_MEGA_A;
                  ct_start  <= 1'b1;
                  r_ct_pend <= 1'b1;
                  r_ct_got  <= 1'b0;
                  r_ws_got  <= 1'b1;
               end
            end
            S_MEGA_A: begin
               if (w_ct_ok && w_ws_ok) begin
                  r_state   <= S_MEGA_B;
                  cs_start  <= 1'b1;
                  r_cs_pend <= 1'b1;
                  r_cs_got  <= 1'b0;
                  if (r_blk != LAST_BLK) begin
                     fetch_start <= 1'b1;
                     fetch_base  <= r_fpos.row + r_fpos.col;
                     fetch_uv    <= (r_fpos.pl != 2'd0);
                     r_fpos      <= w_fpos_n;
                     r_f_pend    <= 1'b1;
                     r_f_got     <= 1'b0;
                  end else begin
                     r_f_got <= 1'b1;
                  end
               end
            end
            S_MEGA_B: begin
               if (w_cs_ok && w_f_ok) begin
                  ws_start  <= 1'b1;
                  ws_base   <= r_wpos.row + r_wpos.col;
                  ws_uv     <= (r_wpos.pl != 2'd0);
                  r_wpos    <= w_wpos_n;
                  r_ws_pend <= 1'b1;
                  r_ws_got  <= 1'b0;
                  if (r_blk == LAST_BLK) begin
                     r_state <= S_LEAD_OUT;
                  end else begin
                     r_state   <= S_MEGA_A;
                     r_blk     <= r_blk + 12'd1;
                     ct_start  <= 1'b1;
                     r_ct_pend <= 1'b1;
                     r_ct_got  <= 1'b0;
                  end
               end
            end
            S_LEAD_OUT: begin
               if (w_ws_ok) begin
                  r_state <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_fpos  <= F_INIT;
               r_wpos  <= W_INIT;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/idct_block_scheduler.md
# idct_block_scheduler

Top-level sequencer for the milestone 2 IDCT datapath. It walks all 2400 8x8 blocks of a 320x240 frame: 1200 Y blocks, then 600 U, then 600 V. For each block it issues start pulses to four engines: Fetch S', Compute T, Compute S and Write S. Engine phases overlap in the lead-in / megastate A / megastate B / lead-out pattern, and the block supplies each memory engine with its SRAM base address.

## Interface
Parameters:
- BLK_ROWS, 30, block rows per plane
- Y_BLK_COLS, 40, block columns in Y
- UV_BLK_COLS, 20, block columns in U/V
- PRE_Y_BASE / PRE_U_BASE / PRE_V_BASE, 76800 / 153600 / 192000, S' segment starts
- OUT_Y_BASE / OUT_U_BASE / OUT_V_BASE, 0 / 38400 / 57600, output segment starts

Ports:
- Clock  in  1  system clock
- Resetn  in  1  asynchronous, active-low reset
- start  in  1  begin frame; sampled only in IDLE
- busy  out  1  high outside IDLE/DONE
- done  out  1  one-cycle pulse at frame completion
- fetch_start  out  1  pulse; Fetch S' engine
- fetch_done  in  1  pulse from Fetch S' engine
- fetch_base  out  18  SRAM word address of block's first S' coefficient
- fetch_uv  out  1  0 = Y stride (320), 1 = U/V stride (160)
- ct_start / ct_done  out / in  1  Compute T handshake
- cs_start / cs_done  out / in  1  Compute S handshake
- ws_start  out  1  pulse; Write S engine
- ws_done  in  1  pulse from Write S engine
- ws_base  out  18  SRAM word address of block's first output pixel pair
- ws_uv  out  1  0 = Y stride (160 words), 1 = U/V stride (80 words)

## Operation
- States: IDLE, LEAD_IN, MEGA_A, MEGA_B, LEAD_OUT, DONE.
- IDLE, start=1 -> LEAD_IN.
  - Fetch block 0.
  - Wait fetch_done, then go to MEGA_A.
- MEGA_A(k):
  - ct_start for block k.
  - ws_start for block k-1 when k>0; ws is treated as already done when k=0.
  - Leave when both dones are latched.
- MEGA_B(k):
  - cs_start for block k.
  - fetch_start for block k+1 when k<2399; fetch is treated as already done when k=2399.
  - When both dones are latched: go to MEGA_A(k+1) if k<2399, else LEAD_OUT.
- LEAD_OUT: ws_start for block 2399; wait ws_done, then go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- Done latches:
  - One latch per engine.
  - Set by the matching *_done pulse.
  - Cleared in the cycle the corresponding *_start is issued.
  - *_done pulses arriving while the engine is not outstanding are ignored.
- Independent block position counters are kept for fetch and write (plane, brow, bcol).
  - bcol wraps at the plane's column count and increments brow.
  - brow wraps at BLK_ROWS and advances the plane Y -> U -> V.
- fetch_base = PRE_plane + brow*8*W + bcol*8, with W=320 (Y) or 160 (U/V).
- ws_base = OUT_plane + brow*8*(W/2) + bcol*4.
- Address arithmetic:
  - Compute incrementally using a row-start register plus column offset; no multipliers.
  - Use 18-bit unsigned values; no value exceeds 229272.
- fetch_uv / ws_uv = 1 for the U and V planes.
- start while busy is ignored.

## Timing
- Reset values:
  - All outputs are 0: fetch_base=0, ws_base=0, all *_start=0, done=0, busy=0.
  - State=IDLE; counters and latches cleared.
- start high in IDLE at edge n -> fetch_start=1 and busy=1 in cycle n+1.
- *_start pulses are registered, exactly one cycle wide, and asserted in the first cycle of the phase.
- Base addresses and uv bits are valid in the same cycle as their start pulse and held until that engine's next start.
- Last required done latched at edge n -> next phase's start pulses in cycle n+1.
  - A done arriving in the same cycle as the final check counts.
- Simultaneous dones from both engines in one cycle are handled in that cycle.
- Resetn low mid-frame: immediate return to reset values; no done pulse; the next frame needs a fresh start.

## Test plan
- Reset, then idle with start=0 for 20 cycles -> all outputs 0, no start pulses.
- start; engines return done 3 cycles after each start:
  - fetch_base=76800 in cycle 1.
  - First MEGA_A issues ct_start only, no ws_start.
  - First MEGA_B issues fetch_base=76808.
- Row wrap: Y block 39 -> 40 gives fetch_base=79360, ws_base for block 40=1280, uv=0.
- Plane wraps:
  - Block 1200 gives fetch_base=153600, ws_base=38400, uv=1.
  - Block 1800 gives 192000 / 57600.
  - Block 2399 gives 229272 / 76236.
- Skewed/stray dones:
  - ct_done 10 cycles before ws_done -> cs_start exactly 1 cycle after ws_done.
  - Extra cs_done in MEGA_A -> ignored.
- Full frame: exactly 2400 pulses of each *_start and one done pulse. A second run after done passes the same checks. Resetn pulsed at block 500 -> outputs 0 and state IDLE.
